// File: rtl/telemetry_tx_scheduler.sv
// Telemetry frame scheduler for a byte-wide UART.
// Emits a 7-byte periodic telemetry frame every PERIOD_CYCLES while enabled and
// interleaves 3-byte event frames requested through a req/ack handshake.
// Each byte is strobed once the UART is idle. The FSM then tracks the UART busy
// flag through its rising and falling edges. Each edge wait is bounded by
// BUSY_TIMEOUT so that a dead UART cannot lock up the scheduler.

module telemetry_tx_scheduler #(
  parameter int PERIOD_CYCLES = 2500000,
  parameter int BUSY_TIMEOUT  = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] heart_rate,
  input  logic [7:0] heart_cap,
  input  logic [7:0] speed,
  input  logic [9:0] angle,
  input  logic       evt_req,
  input  logic [7:0] evt_code,
  output logic       evt_ack,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       frame_active,
  output logic       timeout_err
);

  localparam int TIMER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TOUT_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [TOUT_W-1:0]  TOUT_LAST  = TOUT_W'(BUSY_TIMEOUT - 1);
  localparam logic [7:0] PERIODIC_SYNC = 8'hA5;
  localparam logic [7:0] EVENT_SYNC    = 8'h5A;
  localparam logic [2:0] PERIODIC_LAST = 3'd6;
  localparam logic [2:0] EVENT_LAST    = 3'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    NEXT      = 3'd5
  } schedState_t;

  schedState_t        state_r;
  schedState_t        stateNext_s;
  logic [TIMER_W-1:0] periodTimer_r;
  logic               periodicPending_r;
  logic               lastWasEvent_r;
  logic               frameIsEvent_r;
  logic [7:0]         evtCode_r;
  logic [7:0]         frameBuf_r [8];
  logic [2:0]         lastIdx_r;
  logic [2:0]         byteIdx_r;
  logic [TOUT_W-1:0]  timeoutCnt_r;
  logic               terminalCount_s;
  logic               acceptEvent_s;
  logic               acceptPeriodic_s;
  logic               accept_s;
  logic               loadTx_s;
  logic               timeout_s;
  logic               transmit_r;
  logic [7:0]         txByte_r;
  logic               evtAck_r;
  logic               frameActive_r;
  logic               timeoutErr_r;

  // Additive checksum over the five telemetry payload bytes, wrapping at 8 bits.
  function automatic logic [7:0] frameChecksum(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic [7:0] b4,
    input logic [7:0] b5
  );
    frameChecksum = b1 + b2 + b3 + b4 + b5;
  endfunction

  assign terminalCount_s = enable && (periodTimer_r == TIMER_LAST);
  assign accept_s        = acceptEvent_s | acceptPeriodic_s;

  // Next-state logic: arbitration, byte pacing and busy-edge timeout handling.
  always_comb begin
    stateNext_s      = state_r;
    acceptEvent_s    = 1'b0;
    acceptPeriodic_s = 1'b0;
    loadTx_s         = 1'b0;
    timeout_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          // Events win unless the previous frame was an event and a periodic frame waits.
          if (evt_req && !(periodicPending_r && lastWasEvent_r)) begin
            stateNext_s   = LOAD;
            acceptEvent_s = 1'b1;
          end else if (periodicPending_r) begin
            stateNext_s      = LOAD;
            acceptPeriodic_s = 1'b1;
          end else begin
            stateNext_s = IDLE;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      LOAD: begin
        stateNext_s = SEND;
      end
      SEND: begin
        if (!is_transmitting) begin
          stateNext_s = WAIT_BUSY;
          loadTx_s    = 1'b1;
        end else begin
          stateNext_s = SEND;
        end
      end
      WAIT_BUSY: begin
        if (is_transmitting) begin
          stateNext_s = WAIT_DONE;
        end else if (timeoutCnt_r == TOUT_LAST) begin
          stateNext_s = IDLE;
          timeout_s   = 1'b1;
        end else begin
          stateNext_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          stateNext_s = NEXT;
        end else if (timeoutCnt_r == TOUT_LAST) begin
          stateNext_s = IDLE;
          timeout_s   = 1'b1;
        end else begin
          stateNext_s = WAIT_DONE;
        end
      end
      NEXT: begin
        if (byteIdx_r == lastIdx_r) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = SEND;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Period timer and pending flag; a new terminal count beats the LOAD-time clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      periodTimer_r     <= '0;
      periodicPending_r <= 1'b0;
    end else if (!enable) begin
      periodTimer_r     <= '0;
      periodicPending_r <= 1'b0;
    end else begin
      periodTimer_r <= terminalCount_s ? '0 : periodTimer_r + TIMER_W'(1);
      if (terminalCount_s) begin
        periodicPending_r <= 1'b1;
      end else if ((state_r == LOAD) && !frameIsEvent_r) begin
        periodicPending_r <= 1'b0;
      end else begin
        periodicPending_r <= periodicPending_r;
      end
    end
  end

  // Frame selection bookkeeping captured at the moment a frame is accepted.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lastWasEvent_r <= 1'b0;
      frameIsEvent_r <= 1'b0;
      evtCode_r      <= 8'h00;
    end else if (accept_s) begin
      lastWasEvent_r <= acceptEvent_s;
      frameIsEvent_r <= acceptEvent_s;
      evtCode_r      <= acceptEvent_s ? evt_code : evtCode_r;
    end else begin
      lastWasEvent_r <= lastWasEvent_r;
      frameIsEvent_r <= frameIsEvent_r;
      evtCode_r      <= evtCode_r;
    end
  end

  // Frame snapshot built in LOAD; its contents do not change until the next LOAD.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        frameBuf_r[i] <= 8'h00;
      end
      lastIdx_r <= 3'd0;
    end else if (state_r == LOAD) begin
      if (frameIsEvent_r) begin
        frameBuf_r[0] <= EVENT_SYNC;
        frameBuf_r[1] <= evtCode_r;
        frameBuf_r[2] <= ~evtCode_r;
        frameBuf_r[3] <= 8'h00;
        frameBuf_r[4] <= 8'h00;
        frameBuf_r[5] <= 8'h00;
        frameBuf_r[6] <= 8'h00;
        lastIdx_r     <= EVENT_LAST;
      end else begin
        frameBuf_r[0] <= PERIODIC_SYNC;
        frameBuf_r[1] <= heart_rate;
        frameBuf_r[2] <= heart_cap;
        frameBuf_r[3] <= {6'b000000, angle[9:8]};
        frameBuf_r[4] <= angle[7:0];
        frameBuf_r[5] <= speed;
        frameBuf_r[6] <= frameChecksum(heart_rate, heart_cap,
                                       {6'b000000, angle[9:8]}, angle[7:0], speed);
        lastIdx_r     <= PERIODIC_LAST;
      end
      frameBuf_r[7] <= 8'h00;
    end else begin
      frameBuf_r <= frameBuf_r;
      lastIdx_r  <= lastIdx_r;
    end
  end

  // Byte index: zero while idle, advanced in NEXT when more bytes remain.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      byteIdx_r <= 3'd0;
    end else if (state_r == IDLE) begin
      byteIdx_r <= 3'd0;
    end else if ((state_r == NEXT) && (stateNext_s == SEND)) begin
      byteIdx_r <= byteIdx_r + 3'd1;
    end else begin
      byteIdx_r <= byteIdx_r;
    end
  end

  // Busy-edge watchdog: counts cycles spent in a wait state, cleared on every entry.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      timeoutCnt_r <= '0;
    end else if (((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) &&
                 (stateNext_s == state_r)) begin
      timeoutCnt_r <= timeoutCnt_r + TOUT_W'(1);
    end else begin
      timeoutCnt_r <= '0;
    end
  end

  // Registered outputs derived from the upcoming state and the transition strobes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      transmit_r    <= 1'b0;
      txByte_r      <= 8'h00;
      evtAck_r      <= 1'b0;
      frameActive_r <= 1'b0;
      timeoutErr_r  <= 1'b0;
    end else begin
      transmit_r    <= loadTx_s;
      txByte_r      <= loadTx_s ? frameBuf_r[byteIdx_r] : txByte_r;
      evtAck_r      <= acceptEvent_s;
      frameActive_r <= (stateNext_s != IDLE);
      timeoutErr_r  <= timeout_s;
    end
  end

  assign transmit     = transmit_r;
  assign tx_byte      = txByte_r;
  assign evt_ack      = evtAck_r;
  assign frame_active = frameActive_r;
  assign timeout_err  = timeoutErr_r;

endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// Self-checking bench for telemetry_tx_scheduler.
// A simple UART model reacts to each transmit strobe. Transmitted bytes are
// collected and compared against frames rebuilt from the frame-format rules
// using plain integer arithmetic.

module tb_telemetry_tx_scheduler;

  localparam int PERIOD    = 100;
  localparam int TOUT      = 20;
  localparam int UART_BUSY = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] heartRate;
  logic [7:0] heartCap;
  logic [7:0] speed;
  logic [9:0] angle;
  logic       evtReq;
  logic [7:0] evtCode;
  logic       evtAck;
  logic       isTx;
  logic       transmit;
  logic [7:0] txByte;
  logic       frameActive;
  logic       timeoutErr;

  logic       uartStuck = 1'b0;
  logic [4:0] uartCnt   = 5'd0;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int txCount   = 0;
  int lastTxCyc = 0;
  int ackHigh   = 0;
  int ackRise   = 0;
  int toCount   = 0;
  int toCyc     = 0;
  bit prevAck   = 1'b0;
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  telemetry_tx_scheduler #(
    .PERIOD_CYCLES(PERIOD),
    .BUSY_TIMEOUT (TOUT)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .enable         (enable),
    .heart_rate     (heartRate),
    .heart_cap      (heartCap),
    .speed          (speed),
    .angle          (angle),
    .evt_req        (evtReq),
    .evt_code       (evtCode),
    .evt_ack        (evtAck),
    .is_transmitting(isTx),
    .transmit       (transmit),
    .tx_byte        (txByte),
    .frame_active   (frameActive),
    .timeout_err    (timeoutErr)
  );

  // UART model: busy for UART_BUSY cycles after each strobe, or never when stuck.
  always @(posedge clk) begin
    if (uartStuck) uartCnt <= 5'd0;
    else if (transmit === 1'b1) uartCnt <= 5'(UART_BUSY);
    else if (uartCnt != 5'd0) uartCnt <= uartCnt - 5'd1;
    else uartCnt <= uartCnt;
  end
  assign isTx = (uartCnt != 5'd0);

  task automatic chkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample all outputs mid-cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (transmit === 1'b1) begin
      txCount++;
      rxQ.push_back(txByte);
      lastTxCyc = cyc;
    end
    if (evtAck === 1'b1) begin
      ackHigh++;
      if (!prevAck) ackRise++;
    end
    prevAck = (evtAck === 1'b1);
    if (timeoutErr === 1'b1) begin
      toCount++;
      toCyc = cyc;
    end
  endtask

  task automatic waitTx(input int target, input int budget, input string tag);
    int n = 0;
    while (txCount < target && n < budget) begin
      step();
      n++;
    end
    chkBit(tag, txCount >= target, 1'b1);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (frameActive === 1'b1 && n < budget) begin
      step();
      n++;
    end
    chkBit(tag, frameActive, 1'b0);
  endtask

  // Reference periodic frame: sync, payload, and the payload sum modulo 256.
  task automatic pushPeriodic(input logic [7:0] hr, input logic [7:0] cap,
                              input logic [9:0] ang, input logic [7:0] spd);
    int angHi = int'(ang) / 256;
    int angLo = int'(ang) % 256;
    int sum   = int'(hr) + int'(cap) + angHi + angLo + int'(spd);
    expQ.push_back(8'hA5);
    expQ.push_back(hr);
    expQ.push_back(cap);
    expQ.push_back(8'(angHi));
    expQ.push_back(8'(angLo));
    expQ.push_back(spd);
    expQ.push_back(8'(sum % 256));
  endtask

  // Reference event frame: sync, code, and its bitwise complement.
  task automatic pushEvent(input logic [7:0] code);
    expQ.push_back(8'h5A);
    expQ.push_back(code);
    expQ.push_back(8'(255 - int'(code)));
  endtask

  task automatic compareBytes(input string tag);
    chkInt({tag, "_len"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rxQ.size()) chkByte($sformatf("%s_b%0d", tag, i), rxQ[i], expQ[i]);
    end
    rxQ.delete();
    expQ.delete();
  endtask

  task automatic randomTelemetry();
    heartRate = 8'($urandom);
    heartCap  = 8'($urandom);
    angle     = 10'($urandom);
    speed     = 8'($urandom);
  endtask

  // Directed sequence of scenarios with randomized data.
  initial begin
    int base;
    int ackBase;
    int toBase;
    int relCyc;
    int faSeen;
    int tStart;
    logic [7:0] code;

    reset = 1'b1; enable = 1'b0; evtReq = 1'b0; evtCode = 8'h00;
    heartRate = 8'h00; heartCap = 8'h00; angle = 10'h000; speed = 8'h00;
    repeat (3) step();
    chkBit("rst_transmit", transmit, 1'b0);
    chkByte("rst_tx_byte", txByte, 8'h00);
    chkBit("rst_evt_ack", evtAck, 1'b0);
    chkBit("rst_frame_active", frameActive, 1'b0);
    chkBit("rst_timeout_err", timeoutErr, 1'b0);

    // Known periodic frame, snapshot check, enable dropped mid-frame.
    heartRate = 8'd72; heartCap = 8'd180; angle = 10'h2C3; speed = 8'd15;
    enable = 1'b1; reset = 1'b0; relCyc = cyc; base = txCount;
    rxQ.delete(); expQ.delete();
    waitTx(base + 1, 150, "p0_first_tx_seen");
    chkInt("p0_first_tx_cycle", lastTxCyc - relCyc, PERIOD + 3);
    waitTx(base + 3, 60, "p0_byte3_seen");
    heartRate = 8'd90;
    waitTx(base + 4, 60, "p0_byte4_seen");
    enable = 1'b0;
    waitIdle(150, "p0_idle");
    pushPeriodic(8'd72, 8'd180, 10'h2C3, 8'd15);
    compareBytes("p0_frame");

    // Disabled for three periods with an event request held: nothing happens.
    base = txCount; ackBase = ackRise; faSeen = 0;
    evtReq = 1'b1; evtCode = 8'h33;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step();
      if (frameActive === 1'b1) faSeen++;
    end
    chkInt("dis_tx_count", txCount - base, 0);
    chkInt("dis_ack_count", ackRise - ackBase, 0);
    chkInt("dis_frame_active", faSeen, 0);
    evtReq = 1'b0;
    rxQ.delete();

    // Randomized periodic frames with latency check.
    for (int k = 0; k < 3; k++) begin
      randomTelemetry();
      base = txCount; enable = 1'b1; relCyc = cyc;
      waitTx(base + 1, 150, "pr_first_tx_seen");
      chkInt("pr_latency", lastTxCyc - relCyc, PERIOD + 3);
      enable = 1'b0;
      waitIdle(150, "pr_idle");
      pushPeriodic(heartRate, heartCap, angle, speed);
      compareBytes($sformatf("pr%0d_frame", k));
    end

    // Arbitration: event request meets a pending periodic frame.
    randomTelemetry();
    base = txCount; ackBase = ackRise; tStart = ackHigh; relCyc = cyc;
    enable = 1'b1;
    repeat (PERIOD) step();
    evtReq = 1'b1; evtCode = 8'h11;
    step();
    chkBit("arb_ack_in_load", evtAck, 1'b1);
    waitTx(base + 11, 400, "arb_third_frame_seen");
    evtReq = 1'b0; enable = 1'b0;
    waitIdle(150, "arb_idle");
    pushEvent(8'h11);
    pushPeriodic(heartRate, heartCap, angle, speed);
    pushEvent(8'h11);
    compareBytes("arb_frames");
    chkInt("arb_ack_pulses", ackRise - ackBase, 2);
    chkInt("arb_ack_cycles", ackHigh - tStart, 2);

    // Randomized event-only frames.
    for (int k = 0; k < 2; k++) begin
      code = 8'($urandom);
      base = txCount; ackBase = ackRise; relCyc = cyc;
      evtReq = 1'b1; evtCode = code; enable = 1'b1;
      step();
      chkBit("ev_ack", evtAck, 1'b1);
      evtReq = 1'b0;
      waitTx(base + 1, 50, "ev_first_tx_seen");
      chkInt("ev_latency", lastTxCyc - relCyc, 3);
      waitIdle(100, "ev_idle");
      enable = 1'b0;
      pushEvent(code);
      compareBytes($sformatf("ev%0d_frame", k));
      chkInt("ev_ack_pulses", ackRise - ackBase, 1);
    end

    // UART never raises busy: watchdog aborts the frame.
    randomTelemetry();
    uartStuck = 1'b1;
    base = txCount; toBase = toCount;
    enable = 1'b1;
    waitTx(base + 1, 150, "to_first_tx_seen");
    tStart = lastTxCyc;
    enable = 1'b0;
    begin
      int n = 0;
      while (toCount == toBase && n < 60) begin
        step();
        n++;
      end
    end
    chkBit("to_err_seen", toCount > toBase, 1'b1);
    chkInt("to_err_delay", toCyc - tStart, TOUT);
    chkBit("to_frame_active_low", frameActive, 1'b0);
    step();
    chkBit("to_err_one_cycle", timeoutErr, 1'b0);
    repeat (60) step();
    chkInt("to_no_more_tx", txCount - base, 1);
    chkInt("to_err_pulses", toCount - toBase, 1);
    uartStuck = 1'b0;
    rxQ.delete();

    // Reset in the middle of byte 4, then restart timing from release.
    randomTelemetry();
    base = txCount; enable = 1'b1;
    waitTx(base + 4, 250, "rs_byte4_seen");
    repeat (3) step();
    reset = 1'b1;
    step();
    chkBit("rs_transmit", transmit, 1'b0);
    chkByte("rs_tx_byte", txByte, 8'h00);
    chkBit("rs_evt_ack", evtAck, 1'b0);
    chkBit("rs_frame_active", frameActive, 1'b0);
    chkBit("rs_timeout_err", timeoutErr, 1'b0);
    repeat (2) step();
    reset = 1'b0; relCyc = cyc;
    chkInt("rs_no_tx_in_reset", txCount - base, 4);
    rxQ.delete(); expQ.delete();
    waitTx(base + 5, 150, "rs_restart_tx_seen");
    chkInt("rs_restart_latency", lastTxCyc - relCyc, PERIOD + 3);
    enable = 1'b0;
    waitIdle(150, "rs_idle");
    pushPeriodic(heartRate, heartCap, angle, speed);
    compareBytes("rs_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
